// File: rtl/sfx_pkg.sv
// sfx_pkg: shared constants and helpers for the sound-effect tone player.
//   NOTE_C/D/E/G : default per-channel step dividers (clk cycles per ROM step)
//   DUR_DEFAULT  : default channel sounding time (100 ms at 50 MHz)
//   ch_w()       : channel index width, never narrower than one bit
//   mid_val()    : mid-scale (silent) sample value for a given sample width
package sfx_pkg;

  localparam logic [15:0] NOTE_C = 16'h0BAA;
  localparam logic [15:0] NOTE_D = 16'h0A64;
  localparam logic [15:0] NOTE_E = 16'h0941;
  localparam logic [15:0] NOTE_G = 16'h07C9;

  localparam logic [23:0] DUR_DEFAULT = 24'd5_000_000;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int mid_val(input int sample_w);
    return 1 << (sample_w - 1);
  endfunction

endpackage

// File: rtl/sfx_wave_rom.sv
// sfx_wave_rom: one-period sine table with a registered read port.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, output returns to mid-scale
//   en     : high while a tone is sounding; low forces mid-scale output
//   addr   : table index (2^ADDR_W samples per period)
//   sample : registered sample, ROM[addr] when en, else mid-scale
// The table is computed at elaboration from a quadrant-folded Taylor series,
// so no memory initialisation file is needed.
module sfx_wave_rom
  import sfx_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int SAMPLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam real PI = 3.14159265358979323846;
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(mid_val(SAMPLE_W));

  // Taylor series, only ever evaluated on [0, pi/2] where it converges fast.
  function automatic real sin_q1(input real x);
    real term;
    real acc;
    real x2;
    term = x;
    acc  = x;
    x2   = x * x;
    for (int n = 1; n < 9; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Round half up; the tiny bias keeps exact .5 points (k = 0, DEPTH/2) from
  // falling below the boundary through floating-point noise.
  function automatic int round_half_up(input real v);
    return $rtoi(v + 0.5 + 1.0e-9);
  endfunction

  function automatic int sat_sample(input int v);
    int top;
    top = (1 << SAMPLE_W) - 1;
    if (v < 0)   return 0;
    if (v > top) return top;
    return v;
  endfunction

  function automatic logic [SAMPLE_W-1:0] wave_entry(input int k);
    int  half;
    int  quarter;
    int  kf;
    real s;
    real amp;
    half    = DEPTH / 2;
    quarter = DEPTH / 4;
    amp     = real'((1 << SAMPLE_W) - 1) / 2.0;
    kf      = (half > 0) ? (k % half) : 0;
    if (kf > quarter) kf = half - kf;
    s = sin_q1(2.0 * PI * real'(kf) / real'(DEPTH));
    if (k >= half) s = -s;
    return SAMPLE_W'(sat_sample(round_half_up(amp + amp * s)));
  endfunction

  logic [SAMPLE_W-1:0] rom_tbl [DEPTH];

  for (genvar gk = 0; gk < DEPTH; gk++) begin : g_tbl
    localparam logic [SAMPLE_W-1:0] ENTRY = wave_entry(gk);
    assign rom_tbl[gk] = ENTRY;
  end

  // ---- stage p1: registered sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= MID;
    end else begin
      sample <= en ? rom_tbl[addr] : MID;
    end
  end

endmodule

// File: rtl/sfx_tone_player.sv
// sfx_tone_player: multi-channel sound-effect tone player.
//   clk50mhz     : 50 MHz system clock
//   reset_button : asynchronous active-low reset
//   trigger      : per-channel event level; a rising edge starts/restarts it
//   stop_all     : synchronous silence-and-clear of every channel
//   tono         : registered waveform sample to the DAC pins
//   busy         : high while any channel is pending
//   active_ch    : index of the channel that owns the tone engine
//   done         : one-cycle pulse when a channel's duration runs out
// Each channel runs its own duration timer; the lowest-index pending channel
// owns the shared step divider and waveform ROM.
module sfx_tone_player
  import sfx_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 24,
  parameter int ADDR_W   = 5,
  parameter int SAMPLE_W = 4,
  parameter logic [NUM_CH*DIV_W-1:0] STEP_DIV = {NOTE_G, NOTE_E, NOTE_D, NOTE_C},
  parameter logic [NUM_CH*DUR_W-1:0] DURATION = {4{DUR_DEFAULT}},
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                clk50mhz,
  input  logic                reset_button,
  input  logic [NUM_CH-1:0]   trigger,
  input  logic                stop_all,
  output logic [SAMPLE_W-1:0] tono,
  output logic                busy,
  output logic [CH_W-1:0]     active_ch,
  output logic [NUM_CH-1:0]   done
);

  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pending_nx;
  logic [NUM_CH-1:0] done_nx;
  logic [CH_W-1:0]   owner_nx;
  logic              busy_nx;
  logic              vld_p0;
  logic [DIV_W-1:0]  div_tab [NUM_CH];
  logic [DIV_W-1:0]  cur_div;
  logic [DIV_W-1:0]  cnt_p0;
  logic [DIV_W-1:0]  cnt_nx;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] addr_nx;

  // Per-channel edge detect and duration timers.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_I = STEP_DIV[gi*DIV_W +: DIV_W];
    localparam logic [DUR_W-1:0] DUR_I = DURATION[gi*DUR_W +: DUR_W];

    if (DIV_I < DIV_W'(2)) begin : g_bad_div
      $error("sfx_tone_player: STEP_DIV of channel %0d must be at least 2", gi);
    end
    if (DUR_I == '0) begin : g_bad_dur
      $error("sfx_tone_player: DURATION of channel %0d must be at least 1", gi);
    end

    logic [DUR_W-1:0] remaining;
    logic [DUR_W-1:0] rem_nx;
    logic             pend_nx;
    logic             exp_nx;

    assign div_tab[gi] = DIV_I;
    assign start[gi]   = trigger[gi] & ~trig_q[gi];

    // stop_all beats a same-cycle start; a start beats a same-cycle expiry.
    always_comb begin
      pend_nx = pending[gi];
      rem_nx  = remaining;
      exp_nx  = 1'b0;
      if (stop_all) begin
        pend_nx = 1'b0;
        rem_nx  = '0;
      end else if (start[gi]) begin
        pend_nx = 1'b1;
        rem_nx  = DUR_I;
      end else if (pending[gi]) begin
        if (remaining == DUR_W'(1)) begin
          pend_nx = 1'b0;
          rem_nx  = '0;
          exp_nx  = 1'b1;
        end else begin
          rem_nx = remaining - DUR_W'(1);
        end
      end
    end

    always_ff @(posedge clk50mhz or negedge reset_button) begin
      if (!reset_button) begin
        remaining <= '0;
      end else begin
        remaining <= rem_nx;
      end
    end

    assign pending_nx[gi] = pend_nx;
    assign done_nx[gi]    = exp_nx;
  end

  // Fixed priority on next-state pending so owner and pending register together.
  always_comb begin
    owner_nx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_nx[i]) owner_nx = CH_W'(i);
    end
    busy_nx = |pending_nx;
  end

  assign cur_div = div_tab[active_ch];

  // Phase restarts on any ownership change, including idle -> busy.
  always_comb begin
    cnt_nx  = cnt_p0;
    addr_nx = addr_p0;
    if (!busy_nx || !vld_p0 || (owner_nx != active_ch)) begin
      cnt_nx  = '0;
      addr_nx = '0;
    end else if (cnt_p0 == cur_div - DIV_W'(1)) begin
      cnt_nx  = '0;
      addr_nx = addr_p0 + ADDR_W'(1);
    end else begin
      cnt_nx = cnt_p0 + DIV_W'(1);
    end
  end

  // ---- stage p0: channel state, owner and ROM address ----
  always_ff @(posedge clk50mhz or negedge reset_button) begin
    if (!reset_button) begin
      trig_q    <= '0;
      pending   <= '0;
      done      <= '0;
      active_ch <= '0;
      vld_p0    <= 1'b0;
      cnt_p0    <= '0;
      addr_p0   <= '0;
    end else begin
      trig_q    <= trigger;
      pending   <= pending_nx;
      done      <= done_nx;
      active_ch <= owner_nx;
      vld_p0    <= busy_nx;
      cnt_p0    <= cnt_nx;
      addr_p0   <= addr_nx;
    end
  end

  assign busy = vld_p0;

  sfx_wave_rom #(
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_rom (
    .clk    (clk50mhz),
    .rst_n  (reset_button),
    .en     (vld_p0),
    .addr   (addr_p0),
    .sample (tono)
  );

endmodule

// File: tb/tb_sfx_tone_player.sv
// Bench for sfx_tone_player: small-parameter instance checked every cycle
// against a behavioural model, plus a default-parameter instance for the
// real note divider.
module tb_sfx_tone_player;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int DUR  = 20;
  localparam int NROM = 32;
  localparam int MIDV = 8;
  localparam int DDIV = 2986;

  logic       clk50mhz = 1'b0;
  logic       reset_button = 1'b0;
  logic       stop_all = 1'b0;
  logic       stop_def = 1'b0;
  logic [3:0] trigger = '0;
  logic [3:0] trig_def = '0;
  logic [3:0] tono;
  logic [3:0] tono_def;
  logic       busy;
  logic       busy_def;
  logic [1:0] active_ch;
  logic [1:0] ach_def;
  logic [3:0] done;
  logic [3:0] done_def;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #10 clk50mhz = ~clk50mhz;

  sfx_tone_player #(
    .NUM_CH   (4),
    .STEP_DIV ({4{16'd4}}),
    .DURATION ({4{24'd20}})
  ) dut (
    .clk50mhz     (clk50mhz),
    .reset_button (reset_button),
    .trigger      (trigger),
    .stop_all     (stop_all),
    .tono         (tono),
    .busy         (busy),
    .active_ch    (active_ch),
    .done         (done)
  );

  sfx_tone_player dut_def (
    .clk50mhz     (clk50mhz),
    .reset_button (reset_button),
    .trigger      (trig_def),
    .stop_all     (stop_def),
    .tono         (tono_def),
    .busy         (busy_def),
    .active_ch    (ach_def),
    .done         (done_def)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         rom_m [NROM];
  int         rem_m [N];
  logic [3:0] tprev_m;
  bit         busy_m;
  int         owner_m;
  int         addr_m;
  int         own_start;
  int         exp_tono;
  logic [3:0] exp_done;
  bit         pb;
  int         pa;
  int         po;

  // Waveform address is the number of whole divider periods since the owner
  // took over; the sample shown is the previous cycle's address.
  always @(posedge clk50mhz) begin
    cyc = cyc + 1;
    if (!reset_button) begin
      for (int i = 0; i < N; i++) rem_m[i] = 0;
      tprev_m   = '0;
      busy_m    = 1'b0;
      owner_m   = 0;
      addr_m    = 0;
      own_start = 0;
      exp_tono  = MIDV;
      exp_done  = '0;
    end else begin
      pb = busy_m;
      pa = addr_m;
      po = owner_m;
      exp_tono = pb ? rom_m[pa] : MIDV;
      exp_done = '0;
      for (int i = 0; i < N; i++) begin
        if (stop_all) rem_m[i] = 0;
        else if (trigger[i] && !tprev_m[i]) rem_m[i] = DUR;
        else if (rem_m[i] > 0) begin
          if (rem_m[i] == 1) exp_done[i] = 1'b1;
          rem_m[i] = rem_m[i] - 1;
        end
      end
      tprev_m = trigger;
      busy_m  = 1'b0;
      owner_m = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (rem_m[i] > 0) begin
          busy_m  = 1'b1;
          owner_m = i;
        end
      end
      if (busy_m && (!pb || owner_m != po)) own_start = cyc;
      addr_m = busy_m ? ((cyc - own_start) / DIV) % NROM : 0;
    end
  end

  always @(posedge clk50mhz) begin
    #1;
    if (chk_en && reset_button) begin
      chk("model_tono", 32'(tono), exp_tono);
      chk("model_busy", 32'(busy), 32'(busy_m));
      chk("model_active_ch", 32'(active_ch), owner_m);
      chk("model_done", 32'(done), 32'(exp_done));
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk50mhz);
      #1;
    end
  endtask

  // Trigger high during cycle t; the DUT sees the edge at the end of t.
  task automatic pulse(input int ch, input int t);
    go_to(t);
    @(negedge clk50mhz);
    trigger[ch] = 1'b1;
    go_to(t + 1);
    @(negedge clk50mhz);
    trigger[ch] = 1'b0;
  endtask

  int t;

  initial begin
    for (int k = 0; k < NROM; k++)
      rom_m[k] = $rtoi($floor(7.5 + 7.5 * $sin(2.0 * 3.14159265358979 * k / NROM) + 0.5));

    // Reset state
    repeat (2) @(posedge clk50mhz);
    #1;
    chk("rst_tono", 32'(tono), 8);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active_ch", 32'(active_ch), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_def_tono", 32'(tono_def), 8);
    @(negedge clk50mhz);
    reset_button = 1'b1;
    chk_en = 1'b1;

    // 1: asynchronous reset in the middle of a tone
    t = cyc + 2;
    pulse(2, t);
    go_to(t + 6);
    chk("pre_reset_tono", 32'(tono), 9);
    @(negedge clk50mhz);
    #2;
    reset_button = 1'b0;
    #1;
    chk("async_rst_tono", 32'(tono), 8);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_active_ch", 32'(active_ch), 0);
    go_to(cyc + 2);
    @(negedge clk50mhz);
    reset_button = 1'b1;
    go_to(cyc + 3);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_tono", 32'(tono), 8);

    // 2: single trigger
    t = cyc + 2;
    pulse(2, t);
    go_to(t + 1);
    chk("single_busy_t1", 32'(busy), 1);
    chk("single_ach_t1", 32'(active_ch), 2);
    go_to(t + 2);  chk("single_tono_t2", 32'(tono), 8);
    go_to(t + 6);  chk("single_tono_t6", 32'(tono), 9);
    go_to(t + 10); chk("single_tono_t10", 32'(tono), 10);
    go_to(t + 20);
    chk("single_busy_t20", 32'(busy), 1);
    chk("single_done_t20", 32'(done), 0);
    go_to(t + 21);
    chk("single_busy_t21", 32'(busy), 0);
    chk("single_done_t21", 32'(done), 4);
    chk("single_tono_t21", 32'(tono), 13);
    go_to(t + 22);
    chk("single_tono_t22", 32'(tono), 8);
    chk("single_done_t22", 32'(done), 0);

    // 3: pre-emption by a higher-priority channel
    t = cyc + 2;
    pulse(3, t);
    pulse(0, t + 5);
    go_to(t + 6);
    chk("preempt_ach_t6", 32'(active_ch), 0);
    chk("preempt_tono_t6", 32'(tono), 9);
    go_to(t + 7);  chk("preempt_tono_t7", 32'(tono), 8);
    go_to(t + 21);
    chk("preempt_done3", 32'(done), 8);
    chk("preempt_busy_t21", 32'(busy), 1);
    go_to(t + 26);
    chk("preempt_done0", 32'(done), 1);
    chk("preempt_busy_t26", 32'(busy), 0);

    // 4a: level held high starts once
    t = cyc + 2;
    go_to(t);
    @(negedge clk50mhz);
    trigger[1] = 1'b1;
    go_to(t + 21);
    chk("held_done_t21", 32'(done), 2);
    chk("held_busy_t21", 32'(busy), 0);
    go_to(t + 30); chk("held_busy_t30", 32'(busy), 0);
    go_to(t + 40);
    @(negedge clk50mhz);
    trigger[1] = 1'b0;

    // 4b: retrigger in the cycle where remaining is 1
    t = cyc + 2;
    pulse(1, t);
    pulse(1, t + 20);
    go_to(t + 21);
    chk("retrig_done_t21", 32'(done), 0);
    chk("retrig_busy_t21", 32'(busy), 1);
    go_to(t + 22); chk("retrig_tono_t22", 32'(tono), 14);
    go_to(t + 40); chk("retrig_busy_t40", 32'(busy), 1);
    go_to(t + 41);
    chk("retrig_busy_t41", 32'(busy), 0);
    chk("retrig_done_t41", 32'(done), 2);

    // 5: stop_all against pending channels and a same-cycle start
    t = cyc + 2;
    go_to(t);
    @(negedge clk50mhz);
    trigger[1:0] = 2'b11;
    go_to(t + 1);
    @(negedge clk50mhz);
    trigger[1:0] = 2'b00;
    go_to(t + 5);
    @(negedge clk50mhz);
    stop_all   = 1'b1;
    trigger[2] = 1'b1;
    go_to(t + 6);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_done", 32'(done), 0);
    chk("stop_ach", 32'(active_ch), 0);
    @(negedge clk50mhz);
    stop_all   = 1'b0;
    trigger[2] = 1'b0;
    go_to(t + 7);  chk("stop_tono_t7", 32'(tono), 8);
    go_to(t + 30); chk("stop_busy_t30", 32'(busy), 0);

    // 6: default parameters, C note divider
    t = cyc + 2;
    go_to(t);
    @(negedge clk50mhz);
    trig_def[0] = 1'b1;
    go_to(t + 1);
    chk("def_busy", 32'(busy_def), 1);
    chk("def_ach", 32'(ach_def), 0);
    @(negedge clk50mhz);
    trig_def[0] = 1'b0;
    go_to(t + 2);            chk("def_tono_step0", 32'(tono_def), 8);
    go_to(t + 1 + DDIV);     chk("def_tono_before_step1", 32'(tono_def), 8);
    go_to(t + 2 + DDIV);     chk("def_tono_step1", 32'(tono_def), 9);
    go_to(t + 2 + 8 * DDIV); chk("def_tono_step8", 32'(tono_def), 15);
    chk("def_done_none", 32'(done_def), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_tone_player.md
Name: sfx_tone_player

Overview:
Multi-channel sound-effect player for the game audio path. Each of NUM_CH channels is a fixed tone with its own step divider and duration, fired by a game event such as a paddle hit, brick hit or ball loss. A fixed-priority arbiter picks one sounding channel. That channel's divider steps a shared waveform ROM, which drives the SAMPLE_W-bit tone output. This replaces the free-running note dividers, the gated audio clock and the ad-hoc two-source selection with one synchronous clk50mhz-domain block.

Parameters:
NUM_CH, 4, number of sound channels (1..16)
DIV_W, 16, width of per-channel step divider
DUR_W, 24, width of per-channel duration counter
ADDR_W, 5, waveform ROM address width (2^ADDR_W samples per period)
SAMPLE_W, 4, output sample width
STEP_DIV, {16'h07C9,16'h0941,16'h0A64,16'h0BAA}, packed NUM_CH*DIV_W; channel i slice [i*DIV_W +: DIV_W] = clk cycles per ROM step (ch0=0xBAA); legal range 2..2^DIV_W-1
DURATION, {4{24'd5000000}}, packed NUM_CH*DUR_W; channel i sounding time in clk cycles (100 ms); legal range >=1

Ports:
clk50mhz  in  1  system clock, 50 MHz
reset_button  in  1  asynchronous, active-low reset
trigger  in  NUM_CH  per-channel event, synchronous level; rising edge starts/restarts channel
stop_all  in  1  synchronous, silences and clears all channels
tono  out  SAMPLE_W  registered waveform sample to DAC pins
busy  out  1  high while any channel pending
active_ch  out  CH_W  index of owning channel; CH_W = max(1,clog2(NUM_CH))
done  out  NUM_CH  one-cycle pulse when a channel's duration expires naturally

Behaviour:
- Reset (reset_button=0, async): pending=0, remaining=0, trig_q=0, step cnt=0, addr=0, owner=0, tono=MID=2^(SAMPLE_W-1), busy=0, active_ch=0, done=0.
- Edge detect: trig_q registers trigger. Start(i) = trigger[i] & ~trig_q[i]. A level held high does not retrigger.
- Start(i) at edge t: at t+1 pending[i]=1, remaining[i]=DURATION[i].
- Pending channel remaining counts: each cycle remaining decrements. On the cycle it equals 1, it goes to 0, pending clears and done[i] pulses. A channel therefore sounds exactly DURATION cycles.
- Channels time out independently; a pre-empted channel keeps counting.
- Start(i) on the expiry cycle: start wins. Reload, no done pulse.
- Retrigger of a pending channel: reload remaining; phase unchanged if it is the owner.
- stop_all: at next edge pending=0, remaining=0, busy=0, no done pulses; overrides same-cycle starts.
- Arbiter: owner = lowest-index pending channel, evaluated on next-state pending. busy = |pending. active_ch = owner, registered with pending.
- Tone engine:
  - On owner change (including idle->busy), cnt=0 and addr=0.
  - Otherwise, while busy: if cnt==STEP_DIV[owner]-1 then cnt=0 and addr=addr+1 (mod 2^ADDR_W); else cnt++.
  - While idle, cnt and addr hold 0.
- Output: tono = ROM[addr] registered one cycle after addr while busy. One cycle after busy falls, tono=MID.
- Latency: trigger edge at t -> busy/active_ch at t+1 -> tono=ROM[0] at t+2.
- ROM: entry k = round(A + A*sin(2*pi*k/2^ADDR_W)), A=(2^SAMPLE_W-1)/2, round half up. For defaults: k0=8, k8=15, k16=8, k24=0. Generated at elaboration; no external file.
- Illegal STEP_DIV<2 or DURATION=0: simulation-time error at elaboration.

Decomposition:
- Package sfx_pkg:
  - CH_W function (max(1,clog2)).
  - Default note divider constants C=0xBAA, D=0xA64, E=0x941, G=0x7C9.
  - Default duration.
  - MID constant helper.
- Sub-module sfx_wave_rom (params ADDR_W, SAMPLE_W; registered read, addr in, sample out), instantiated once.
- Arbiter and per-channel timers stay in the top block (generate loop).

Test Plan:
1. Bench params NUM_CH=4, STEP_DIV all 4, DURATION all 20. Hold reset_button=0 mid-sound -> tono=8, busy=0, done=0 immediately (async). Release -> outputs stay idle.
2. Single trigger: pulse trigger[2] at t -> busy=1, active_ch=2 at t+1; tono=ROM[0]=8 at t+2; addr steps every 4 cycles (ROM[1]=9 at t+6); busy falls at t+21; done[2] pulses one cycle at t+21; tono=8 at t+22.
3. Pre-emption: trigger[3] at t, trigger[0] at t+5 -> active_ch 3 then 0 at t+6 with addr reset (tono=8 at t+7). Ch0 expires at t+26 -> done[0] pulses. Ch3 already expired at t+21 (done[3] pulsed while pre-empted), so busy=0 at t+26.
4. Retrigger: hold trigger[1] high for 40 cycles -> only one start; expires at t+21. Re-pulse on its expiry cycle -> no done pulse; busy continues 20 more cycles; phase continuous.
5. stop_all with channels 0,1 pending plus a same-cycle trigger[2] edge -> next cycle busy=0, pending=0, no done pulses, tono=MID one cycle later.
6. Defaults (NUM_CH=4, STEP_DIV 0xBAA): after trigger[0], addr steps every 2986 cycles; full 32-step wave period = 95552 cycles (~523 Hz); ROM[8]=15 observed at step 8.
